even_odd_count_monitor: RTL and testbench
=========================================

// Module: even_odd_count_monitor
// PURPOSE
//  Checker stage downstream of the even/odd step counter. Taps the counter's load, mode and data_in
//  inputs plus its count output, and verifies every cycle that count steps by +2 (mod 2^W) with the
//  parity selected by mode. Reports sticky step/parity errors, a saturating wrap count and a one-cycle
//  target-hit pulse. Sits beside the counter in the datapath; it is observation-only and never drives the counter.
// PARAMETERS
//  W    4  width of count/data_in/target
//  CW   8  width of wrap_cnt (saturating)
// PORTS
//  clk        in   1   sole clock, all state on posedge
//  rst_n      in   1   reset, asynchronous, active-low
//  load       in   1   counter load strobe (same signal that drives the counter)
//  mode       in   1   0 = even sequence, 1 = odd sequence; sampled only when load=1
//  data_in    in   W   counter load value
//  count      in   W   counter output under check
//  target     in   W   hit compare value
//  target_en  in   1   enables hit generation
//  clr        in   1   clears step_err, par_err, wrap_cnt
//  locked     out  1   1 when state==CHECK
//  hit        out  1   one-cycle pulse, count reached target
//  step_err   out  1   sticky: count != expected
//  par_err    out  1   sticky: count[0] != captured mode
//  wrap_cnt   out  CW  saturating count of verified wrap-arounds
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, exp=0, mode_q=0, prev_hit=0; all outputs 0.
//  FSM: IDLE -(load)-> CHECK; CHECK -(step mismatch, no load)-> RESYNC; RESYNC -(load)-> CHECK;
//   CHECK -(load)-> CHECK. In IDLE/RESYNC: no compares, no wraps, no hits.
//  Any posedge with load=1: exp<=data_in, mode_q<=mode, state<=CHECK.
//  Compare on every posedge in CHECK (including a load edge; count still holds the pre-load value):
//   step_err set if count!=exp; par_err set if count[0]!=mode_q. If load=0, exp<=exp+2 (mod 2^W).
//  Errors are registered: visible on the edge after the offending sample. Latency 1 cycle for all outputs.
//  Wrap: compare passes, load=0, exp+2 overflows W bits (count>=2^W-2) -> wrap_cnt+1; holds at 2^CW-1.
//  Hit: CHECK && target_en && count==target && !prev_hit -> hit=1 for one cycle; prev_hit tracks the
//   raw equality term, so a count held at target yields a single pulse.
//  clr same edge as a new error/wrap: the new event wins (flag set / wrap_cnt=1); otherwise clears to 0.
//  A data_in whose parity disagrees with mode is not rejected; it produces par_err on the first compare.
//  A change on mode while load=0 is ignored (mode_q is unchanged).
//  rst_n asserted mid-sequence: immediate return to reset values; the next load is required to lock.
// STRUCTURE
//  Package even_odd_pkg: state enum {IDLE, CHECK, RESYNC} (2-bit), localparam STEP=2.
//  One sub-module: sat_counter (CW-wide, inc/clr, saturating) for wrap_cnt. All other logic inline.
// TESTING
//  1 load=1,data_in=2,mode=0, then 6 free cycles of a correct counter -> locked=1, no errors, wrap_cnt=0.
//  2 load data_in=12,mode=0, run 4 cycles (12,14,0,2) -> wrap_cnt=1 one edge after the 14->0 sample.
//  3 load 3,mode=1; force count=6 on 3rd cycle -> step_err=1 and par_err=1 next edge, locked=0;
//    reload 3 -> locked=1, errors stay 1 until clr.
//  4 target=9,target_en=1, load 3,mode=1 -> hit single pulse one edge after count==9; none in RESYNC.
//  5 clr asserted on the same edge as a mismatch -> step_err=1 (set wins); clr alone -> 0.
//  6 rst_n low mid-count (async, between edges) -> all outputs 0 immediately; no compares until next load.

Source files
------------

// File: rtl/even_odd_count_monitor_pkg.sv
// Shared types and constants for the even/odd step-counter monitor.
// The checker FSM states and the expected per-cycle increment live here.
package even_odd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        RESYNC = 2'd2
    } state_t;

    localparam int STEP = 2;

endpackage

// File: rtl/even_odd_count_monitor_sat_counter.sv
// Saturating up-counter with clear. Increment outranks clear, so an event that
// coincides with a clear leaves the counter at 1 rather than 0.
module sat_counter #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] cnt
);

    logic [CW-1:0] r_cnt;
    logic          w_full;

    assign w_full = &r_cnt;
    assign cnt    = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (inc) begin
            if (clr)
                r_cnt <= CW'(1);
            else if (!w_full)
                r_cnt <= r_cnt + CW'(1);
        end else if (clr) begin
            r_cnt <= '0;
        end
    end

endmodule

// File: rtl/even_odd_count_monitor.sv
// Observation-only checker beside the even/odd step counter: verifies +2 stepping
// and parity, and reports sticky errors, a saturating wrap count and a hit pulse.
//
// state  | meaning
// IDLE   | not yet locked since reset; waiting for the first load
// CHECK  | locked; count compared against the expected value every edge
// RESYNC | lost lock on a step mismatch; waiting for a load to relock
module even_odd_count_monitor
    import even_odd_pkg::*;
#(
    parameter int W  = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          mode,
    input  logic [W-1:0]  data_in,
    input  logic [W-1:0]  count,
    input  logic [W-1:0]  target,
    input  logic          target_en,
    input  logic          clr,
    output logic          locked,
    output logic          hit,
    output logic          step_err,
    output logic          par_err,
    output logic [CW-1:0] wrap_cnt
);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [W-1:0]   r_exp;
    logic           r_mode_q;
    logic           r_prev_hit;
    logic           r_hit;
    logic           r_step_err;
    logic           r_par_err;

    logic           w_check;
    logic           w_step_mis;
    logic           w_par_mis;
    logic [W:0]     w_exp_sum;
    logic           w_wrap;
    logic           w_hit_term;

    assign w_check    = (r_state == CHECK);
    assign w_step_mis = w_check && (count != r_exp);
    assign w_par_mis  = w_check && (count[0] != r_mode_q);
    assign w_exp_sum  = {1'b0, r_exp} + (W+1)'(STEP);
    // Carry out of exp+STEP marks the sample where the counter rolls over.
    assign w_wrap     = w_check && !w_step_mis && !load && w_exp_sum[W];
    assign w_hit_term = w_check && target_en && (count == target);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (load)
            w_state_nxt = CHECK;
        else if (w_step_mis)
            w_state_nxt = RESYNC;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exp      <= '0;
            r_mode_q   <= 1'b0;
            r_prev_hit <= 1'b0;
            r_hit      <= 1'b0;
            r_step_err <= 1'b0;
            r_par_err  <= 1'b0;
        end else begin
            if (load) begin
                r_exp    <= data_in;
                r_mode_q <= mode;
            end else if (w_check) begin
                r_exp <= w_exp_sum[W-1:0];
            end
            r_prev_hit <= w_hit_term;
            r_hit      <= w_hit_term && !r_prev_hit;
            r_step_err <= w_step_mis || (r_step_err && !clr);
            r_par_err  <= w_par_mis  || (r_par_err  && !clr);
        end
    end

    sat_counter #(.CW(CW)) u_wrap_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_wrap),
        .clr   (clr),
        .cnt   (wrap_cnt)
    );

    assign locked   = w_check;
    assign hit      = r_hit;
    assign step_err = r_step_err;
    assign par_err  = r_par_err;

endmodule

// File: tb/tb_even_odd_count_monitor.sv
// Directed bench for even_odd_count_monitor: one task per scenario, inline checks.
module tb_even_odd_count_monitor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load, mode, target_en, clr;
    logic [3:0] data_in, count, target;
    logic       locked, hit, step_err, par_err;
    logic [7:0] wrap_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    even_odd_count_monitor #(.W(4), .CW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .mode      (mode),
        .data_in   (data_in),
        .count     (count),
        .target    (target),
        .target_en (target_en),
        .clr       (clr),
        .locked    (locked),
        .hit       (hit),
        .step_err  (step_err),
        .par_err   (par_err),
        .wrap_cnt  (wrap_cnt)
    );

    // Drive one cycle of inputs at negedge, return just after the next posedge.
    task automatic cyc(input logic ld, input logic md, input logic [3:0] din,
                       input logic [3:0] cnt, input logic cl);
        @(negedge clk);
        load = ld; mode = md; data_in = din; count = cnt; clr = cl;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; load = 0; mode = 0; data_in = 0; count = 0;
        target = 0; target_en = 0; clr = 0;
        #12;
        checks++;
        if ({locked, hit, step_err, par_err, wrap_cnt} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: got locked=%b hit=%b step=%b par=%b wrap=%0d, want all 0",
                     locked, hit, step_err, par_err, wrap_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_lock_and_run;
        cyc(1, 0, 4'd2, 4'd0, 0);
        checks++;
        if (locked !== 1'b1) begin
            errors++; $display("FAIL lock_first: locked=%b want 1", locked);
        end
        // mode toggling with load low must not affect parity checking
        for (int i = 0; i < 6; i++) cyc(0, i[0], 4'd0, 4'(2 + 2*i), 0);
        checks++;
        if ({locked, step_err, par_err} !== 3'b100 || wrap_cnt !== 8'd0) begin
            errors++;
            $display("FAIL free_run: locked=%b step=%b par=%b wrap=%0d want 1 0 0 0",
                     locked, step_err, par_err, wrap_cnt);
        end
    endtask

    task automatic test_wrap;
        cyc(1, 0, 4'd12, 4'd14, 0);
        cyc(0, 0, 4'd0, 4'd12, 0);
        checks++;
        if (wrap_cnt !== 8'd0) begin
            errors++; $display("FAIL wrap_before: wrap=%0d want 0", wrap_cnt);
        end
        cyc(0, 0, 4'd0, 4'd14, 0);
        checks++;
        if (wrap_cnt !== 8'd1) begin
            errors++; $display("FAIL wrap_after: wrap=%0d want 1", wrap_cnt);
        end
        cyc(0, 0, 4'd0, 4'd0, 0);
        cyc(0, 0, 4'd0, 4'd2, 0);
        checks++;
        if (wrap_cnt !== 8'd1 || step_err !== 1'b0) begin
            errors++; $display("FAIL wrap_hold: wrap=%0d step=%b want 1 0", wrap_cnt, step_err);
        end
    endtask

    task automatic test_mismatch_resync;
        cyc(1, 1, 4'd3, 4'd4, 0);
        cyc(0, 0, 4'd0, 4'd3, 0);
        cyc(0, 0, 4'd0, 4'd5, 0);
        checks++;
        if ({locked, step_err, par_err} !== 3'b100) begin
            errors++; $display("FAIL odd_run: locked=%b step=%b par=%b want 1 0 0", locked, step_err, par_err);
        end
        cyc(0, 0, 4'd0, 4'd6, 0);
        checks++;
        if ({locked, step_err, par_err} !== 3'b011) begin
            errors++; $display("FAIL mismatch: locked=%b step=%b par=%b want 0 1 1", locked, step_err, par_err);
        end
        cyc(0, 0, 4'd0, 4'd8, 0);
        checks++;
        if (locked !== 1'b0) begin
            errors++; $display("FAIL resync_hold: locked=%b want 0", locked);
        end
        cyc(1, 1, 4'd3, 4'd8, 0);
        cyc(0, 0, 4'd0, 4'd3, 0);
        checks++;
        if ({locked, step_err, par_err} !== 3'b111) begin
            errors++; $display("FAIL relock_sticky: locked=%b step=%b par=%b want 1 1 1", locked, step_err, par_err);
        end
        cyc(0, 0, 4'd0, 4'd5, 1);
        checks++;
        if ({step_err, par_err} !== 2'b00 || wrap_cnt !== 8'd0 || locked !== 1'b1) begin
            errors++; $display("FAIL clr_all: step=%b par=%b wrap=%0d locked=%b want 0 0 0 1",
                               step_err, par_err, wrap_cnt, locked);
        end
    endtask

    task automatic test_hit;
        logic [4:0] got;
        target = 4'd9; target_en = 1'b1;
        got = '0;
        cyc(1, 1, 4'd3, 4'd7, 0);  got[0] = hit;
        cyc(0, 1, 4'd0, 4'd3, 0);  got[1] = hit;
        cyc(0, 1, 4'd0, 4'd5, 0);  got[2] = hit;
        cyc(0, 1, 4'd0, 4'd7, 0);  got[3] = hit;
        checks++;
        if (got[3:0] !== 4'b0000) begin
            errors++; $display("FAIL hit_early: hits=%b want 0000", got[3:0]);
        end
        cyc(0, 1, 4'd0, 4'd9, 0);
        checks++;
        if (hit !== 1'b1) begin
            errors++; $display("FAIL hit_pulse: hit=%b want 1", hit);
        end
        cyc(0, 1, 4'd0, 4'd11, 0);
        checks++;
        if (hit !== 1'b0) begin
            errors++; $display("FAIL hit_end: hit=%b want 0", hit);
        end
        cyc(1, 1, 4'd9, 4'd13, 0);
        cyc(0, 1, 4'd0, 4'd9, 0);
        checks++;
        if (hit !== 1'b1) begin
            errors++; $display("FAIL hit_second: hit=%b want 1", hit);
        end
        cyc(0, 1, 4'd0, 4'd9, 0);
        checks++;
        if ({hit, step_err, locked} !== 3'b010) begin
            errors++; $display("FAIL hit_held: hit=%b step=%b locked=%b want 0 1 0", hit, step_err, locked);
        end
        cyc(0, 1, 4'd0, 4'd9, 0);
        checks++;
        if (hit !== 1'b0) begin
            errors++; $display("FAIL hit_resync: hit=%b want 0", hit);
        end
        target_en = 1'b0;
    endtask

    task automatic test_clr_priority;
        cyc(1, 0, 4'd4, 4'd0, 0);
        cyc(0, 1, 4'd0, 4'd4, 0);
        checks++;
        if ({locked, step_err} !== 2'b11) begin
            errors++; $display("FAIL pre_clr: locked=%b step=%b want 1 1", locked, step_err);
        end
        cyc(0, 0, 4'd0, 4'd7, 1);
        checks++;
        if ({step_err, par_err} !== 2'b11) begin
            errors++; $display("FAIL clr_vs_err: step=%b par=%b want 1 1", step_err, par_err);
        end
        cyc(0, 0, 4'd0, 4'd0, 1);
        checks++;
        if ({step_err, par_err, locked} !== 3'b000) begin
            errors++; $display("FAIL clr_alone: step=%b par=%b locked=%b want 0 0 0", step_err, par_err, locked);
        end
    endtask

    task automatic test_async_reset;
        int bad;
        cyc(1, 0, 4'd12, 4'd0, 0);
        cyc(0, 0, 4'd0, 4'd12, 0);
        cyc(0, 0, 4'd0, 4'd14, 0);
        cyc(0, 0, 4'd0, 4'd1, 0);
        checks++;
        if (wrap_cnt !== 8'd1 || step_err !== 1'b1 || par_err !== 1'b1) begin
            errors++; $display("FAIL pre_reset: wrap=%0d step=%b par=%b want 1 1 1", wrap_cnt, step_err, par_err);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({locked, hit, step_err, par_err, wrap_cnt} !== 12'h000) begin
            errors++;
            $display("FAIL async_reset: locked=%b hit=%b step=%b par=%b wrap=%0d want all 0",
                     locked, hit, step_err, par_err, wrap_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 4'd0, 4'(5 + i), 0);
            if ({locked, step_err, par_err} !== 3'b000) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL post_reset_idle: %0d bad cycles want 0", bad);
        end
        cyc(1, 0, 4'd2, 4'd9, 0);
        cyc(0, 0, 4'd0, 4'd2, 0);
        checks++;
        if ({locked, step_err, par_err} !== 3'b100) begin
            errors++; $display("FAIL relock_after_reset: locked=%b step=%b par=%b want 1 0 0",
                               locked, step_err, par_err);
        end
    endtask

    initial begin
        test_reset();
        test_lock_and_run();
        test_wrap();
        test_mismatch_resync();
        test_hit();
        test_clr_priority();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
